// File: rtl/fir_output_sink_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fir_output_sink_pkg
//  Description : Shared constants and types for the FIR output sink. Holds
//                the FIR datapath width and order, the sink state type and
//                the default decimation ratio.
//  Macros      : none
//  Revision    : 1.0 - initial release
// ============================================================================
package fir_output_sink_pkg;

    // FIR datapath constants shared with the filter core.
    localparam int width = 16;
    localparam int order = 5;

    // Default decimation ratio applied to the filtered stream.
    localparam int DECIM_DEFAULT = 2;

    // Sink operating state: discarding the start-up transient, or running.
    typedef enum logic [0:0] {
        ST_WARMUP = 1'b0,
        ST_RUN    = 1'b1
    } sink_state_t;

    // Counter width able to index 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_sink_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fir_sink_fifo
//  Description : Synchronous FIFO with registered storage and an explicit
//                occupancy counter. A write while full is accepted only when
//                a read happens in the same cycle, so the slot being vacated
//                is reused and occupancy stays at DEPTH.
//  Macros      : none
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_sink_fifo
    import fir_output_sink_pkg::*;
#(
    parameter int WIDTH = width,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_rd;
    logic             do_wr;

    // A read only pops real data; a full FIFO accepts a write only when it
    // is simultaneously being read.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Storage, pointers and occupancy; storage is cleared so the head reads
    // zero after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fir_output_sink.sv
`default_nettype none
// ============================================================================
//  Module      : fir_output_sink
//  Description : Receiving end of the FIR output stream. Discards the first
//                WARMUP samples after reset, keeps one of every DECIM samples
//                thereafter, and buffers kept samples in a FIFO drained over a
//                valid/ready handshake. Dropped samples raise a sticky
//                overflow flag.
//  Macros      : FIR_SINK_PEAK_EN - adds peak/peak_clr and a running maximum
//                of kept samples.
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_output_sink
    import fir_output_sink_pkg::*;
#(
    parameter int WIDTH  = width,
    parameter int WARMUP = order - 1,
    parameter int DECIM  = DECIM_DEFAULT,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_en,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     clear_ovf
`ifdef FIR_SINK_PEAK_EN
    ,
    output logic [WIDTH-1:0]         peak,
    input  logic                     peak_clr
`endif
);

    localparam int WCNT_W = cnt_width(WARMUP);
    localparam int PH_W   = cnt_width(DECIM);

    // With no warm-up the sink starts out running.
    localparam sink_state_t RESET_STATE = (WARMUP == 0) ? ST_RUN : ST_WARMUP;

    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'((WARMUP == 0) ? 0 : WARMUP - 1);
    localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(DECIM - 1);
    localparam logic [PH_W-1:0]   PH_ONE    = PH_W'(1);

    sink_state_t       state;
    sink_state_t       state_next;
    logic [WCNT_W-1:0] wcnt;
    logic [WCNT_W-1:0] wcnt_next;
    logic [PH_W-1:0]   phase;
    logic [PH_W-1:0]   phase_next;
    logic              kept;

    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              ovf_event;

    // State, warm-up counter and decimation phase registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RESET_STATE;
            wcnt  <= '0;
            phase <= '0;
        end else begin
            state <= state_next;
            wcnt  <= wcnt_next;
            phase <= phase_next;
        end
    end

    // Warm-up sequencing and decimation: only enabled samples move counters,
    // and a RUN sample is kept when the phase is at zero before advancing.
    always_comb begin
        state_next = state;
        wcnt_next  = wcnt;
        phase_next = phase;
        kept       = 1'b0;
        case (state)
            ST_WARMUP: begin
                if (in_en) begin
                    wcnt_next = wcnt + WCNT_ONE;
                    if (wcnt == WCNT_LAST) begin
                        state_next = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (in_en) begin
                    kept       = (phase == '0);
                    phase_next = (phase == PH_LAST) ? '0 : phase + PH_ONE;
                end
            end
            default: begin
                state_next = RESET_STATE;
            end
        endcase
    end

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;

    // A kept sample is lost only when the FIFO is full and nothing leaves it
    // in the same cycle.
    assign ovf_event = kept && fifo_full && !pop;

    fir_sink_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (kept),
        .wr_data (in_data),
        .rd_en   (out_ready),
        .head    (out_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (count)
    );

    // Sticky overflow; a new drop takes priority over a clear request.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (ovf_event) begin
            overflow <= 1'b1;
        end else if (clear_ovf) begin
            overflow <= 1'b0;
        end
    end

`ifdef FIR_SINK_PEAK_EN
    // Running maximum of kept samples, dropped ones included; a clear that
    // coincides with a kept sample restarts the maximum from that sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            peak <= '0;
        end else if (peak_clr) begin
            peak <= kept ? in_data : '0;
        end else if (kept && (in_data > peak)) begin
            peak <= in_data;
        end
    end
`else
    // Peak tracking is not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_fir_output_sink.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fir_output_sink
//  Description : Self-checking bench for fir_output_sink. Three instances
//                with different WARMUP/DECIM settings run directed scenarios
//                and a randomized phase against a queue-based reference model.
//  Macros      : FIR_SINK_PEAK_EN - enables peak checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_output_sink;
    import fir_output_sink_pkg::*;

    localparam int W     = width;
    localparam int DEPTH = 8;

    logic           clk = 1'b0;
    logic [2:0]     rst;
    logic [2:0]     in_en;
    logic [2:0]     ready;
    logic [2:0]     clr_ovf;
    logic [2:0]     pclr;
    logic [W-1:0]   din  [3];
    logic [W-1:0]   dout [3];
    logic [2:0]     oval;
    logic [3:0]     cnt  [3];
    logic [2:0]     ovf;
    logic [W-1:0]   pk   [3];

    int wu [3] = '{4, 0, 0};
    int dc [3] = '{2, 1, 3};

    // Reference model state
    logic [W-1:0] mq0 [$];
    logic [W-1:0] mq1 [$];
    logic [W-1:0] mq2 [$];
    int           n_seen  [3];
    bit           m_ovf   [3];
    logic [W-1:0] m_peak  [3];
    bit           was_rst [3];

    // Values observed leaving each DUT
    logic [W-1:0] coll0 [$];
    logic [W-1:0] coll1 [$];
    logic [W-1:0] coll2 [$];

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    fir_output_sink #(.WIDTH(W), .WARMUP(4), .DECIM(2), .DEPTH(DEPTH)) dut0 (
        .clk(clk), .reset(rst[0]), .in_data(din[0]), .in_en(in_en[0]),
        .out_data(dout[0]), .out_valid(oval[0]), .out_ready(ready[0]),
        .count(cnt[0]), .overflow(ovf[0]), .clear_ovf(clr_ovf[0])
`ifdef FIR_SINK_PEAK_EN
        , .peak(pk[0]), .peak_clr(pclr[0])
`endif
    );

    fir_output_sink #(.WIDTH(W), .WARMUP(0), .DECIM(1), .DEPTH(DEPTH)) dut1 (
        .clk(clk), .reset(rst[1]), .in_data(din[1]), .in_en(in_en[1]),
        .out_data(dout[1]), .out_valid(oval[1]), .out_ready(ready[1]),
        .count(cnt[1]), .overflow(ovf[1]), .clear_ovf(clr_ovf[1])
`ifdef FIR_SINK_PEAK_EN
        , .peak(pk[1]), .peak_clr(pclr[1])
`endif
    );

    fir_output_sink #(.WIDTH(W), .WARMUP(0), .DECIM(3), .DEPTH(DEPTH)) dut2 (
        .clk(clk), .reset(rst[2]), .in_data(din[2]), .in_en(in_en[2]),
        .out_data(dout[2]), .out_valid(oval[2]), .out_ready(ready[2]),
        .count(cnt[2]), .overflow(ovf[2]), .clear_ovf(clr_ovf[2])
`ifdef FIR_SINK_PEAK_EN
        , .peak(pk[2]), .peak_clr(pclr[2])
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int msize(input int k);
        case (k)
            0:       return mq0.size();
            1:       return mq1.size();
            default: return mq2.size();
        endcase
    endfunction

    function automatic logic [W-1:0] mfront(input int k);
        case (k)
            0:       return mq0[0];
            1:       return mq1[0];
            default: return mq2[0];
        endcase
    endfunction

    task automatic record(input int k, input logic [W-1:0] v);
        case (k)
            0:       coll0.push_back(v);
            1:       coll1.push_back(v);
            default: coll2.push_back(v);
        endcase
    endtask

    // Behavioural model: a sample is kept when at least WARMUP samples have
    // been seen before it and its post-warm-up index is a multiple of DECIM.
    task automatic model_step(input int k);
        logic [W-1:0] q [$];
        bit kept;
        bit pop;
        bit evt;
        case (k)
            0:       q = mq0;
            1:       q = mq1;
            default: q = mq2;
        endcase
        was_rst[k] = rst[k];
        if (rst[k]) begin
            q = {};
            n_seen[k] = 0;
            m_ovf[k]  = 1'b0;
            m_peak[k] = '0;
        end else begin
            pop  = (q.size() > 0) && ready[k];
            kept = 1'b0;
            evt  = 1'b0;
            if (in_en[k]) begin
                kept = (n_seen[k] >= wu[k]) && (((n_seen[k] - wu[k]) % dc[k]) == 0);
                n_seen[k]++;
            end
            if (pop) void'(q.pop_front());
            if (kept) begin
                if (q.size() < DEPTH) q.push_back(din[k]);
                else evt = 1'b1;
            end
            m_ovf[k] = (m_ovf[k] && !clr_ovf[k]) || evt;
            if (pclr[k]) m_peak[k] = kept ? din[k] : '0;
            else if (kept && din[k] > m_peak[k]) m_peak[k] = din[k];
        end
        case (k)
            0:       mq0 = q;
            1:       mq1 = q;
            default: mq2 = q;
        endcase
    endtask

    task automatic check_dut(input int k);
        int sz;
        sz = msize(k);
        chk($sformatf("dut%0d.out_valid", k), {31'd0, oval[k]}, {31'd0, sz > 0});
        chk($sformatf("dut%0d.count", k), {28'd0, cnt[k]}, sz);
        chk($sformatf("dut%0d.overflow", k), {31'd0, ovf[k]}, {31'd0, m_ovf[k]});
        if (sz > 0) chk($sformatf("dut%0d.out_data", k), {16'd0, dout[k]}, {16'd0, mfront(k)});
        else if (was_rst[k]) chk($sformatf("dut%0d.out_data_rst", k), {16'd0, dout[k]}, 0);
`ifdef FIR_SINK_PEAK_EN
        chk($sformatf("dut%0d.peak", k), {16'd0, pk[k]}, {16'd0, m_peak[k]});
`endif
    endtask

    // One clock: log pops, advance the model on the edge, check 1 time unit
    // later, then release the single-cycle pulses.
    task automatic step();
        for (int k = 0; k < 3; k++) begin
            if (oval[k] && ready[k] && !rst[k]) record(k, dout[k]);
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_step(k);
        #1;
        for (int k = 0; k < 3; k++) check_dut(k);
        in_en   = '0;
        clr_ovf = '0;
        pclr    = '0;
        rst     = '0;
    endtask

    task automatic push(input int k, input logic [W-1:0] d);
        in_en[k] = 1'b1;
        din[k]   = d;
        step();
    endtask

    task automatic reset_one(input int k);
        rst[k] = 1'b1;
        step();
    endtask

    initial begin
        rst = '1; in_en = '0; ready = '0; clr_ovf = '0; pclr = '0;
        for (int k = 0; k < 3; k++) begin
            din[k] = '0; n_seen[k] = 0; m_ovf[k] = 1'b0; m_peak[k] = '0; was_rst[k] = 1'b0;
        end

        // Reset state for all instances (checked inside step)
        rst = '1; step();
        rst = '1; step();

        // Warm-up and decimation: 1..12 -> 5,7,9,11
        coll0 = {};
        ready[0] = 1'b1;
        for (int i = 1; i <= 12; i++) push(0, W'(i));
        step(); step();
        chk("warmup_decim.n_out", coll0.size(), 4);
        for (int i = 0; i < 4 && i < coll0.size(); i++)
            chk($sformatf("warmup_decim.out%0d", i), {16'd0, coll0[i]}, 5 + 2 * i);

        // Overflow: 1..10 with no reads, then drain 1..8
        reset_one(1);
        ready[1] = 1'b0;
        for (int i = 1; i <= 9; i++) push(1, W'(i));
        chk("ovf.count", {28'd0, cnt[1]}, 8);
        chk("ovf.flag", {31'd0, ovf[1]}, 1);
        push(1, W'(10));
        coll1 = {};
        ready[1] = 1'b1;
        for (int i = 0; i < 9; i++) step();
        chk("ovf.n_drained", coll1.size(), 8);
        for (int i = 0; i < 8 && i < coll1.size(); i++)
            chk($sformatf("ovf.drain%0d", i), {16'd0, coll1[i]}, i + 1);

        // Full FIFO with simultaneous read and write
        reset_one(1);
        ready[1] = 1'b0;
        for (int i = 11; i <= 18; i++) push(1, W'(i));
        coll1 = {};
        ready[1] = 1'b1;
        push(1, W'(20));
        chk("full_rw.count", {28'd0, cnt[1]}, 8);
        chk("full_rw.overflow", {31'd0, ovf[1]}, 0);
        for (int i = 0; i < 9; i++) step();
        chk("full_rw.n_drained", coll1.size(), 9);
        if (coll1.size() > 0) chk("full_rw.last", {16'd0, coll1[coll1.size() - 1]}, 20);

        // clear_ovf coincident with an overflow event
        reset_one(1);
        ready[1] = 1'b0;
        for (int i = 1; i <= 9; i++) push(1, W'(i));
        clr_ovf[1] = 1'b1;
        push(1, W'(10));
        chk("clr_vs_set.overflow", {31'd0, ovf[1]}, 1);
        clr_ovf[1] = 1'b1;
        step();
        chk("clr_alone.overflow", {31'd0, ovf[1]}, 0);
        ready[1] = 1'b1;
        for (int i = 0; i < 9; i++) step();

        // Gapped input, DECIM=3: 1..9 -> 1,4,7
        reset_one(2);
        coll2 = {};
        ready[2] = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            push(2, W'(i));
            step();
        end
        step();
        chk("gapped.n_out", coll2.size(), 3);
        for (int i = 0; i < 3 && i < coll2.size(); i++)
            chk($sformatf("gapped.out%0d", i), {16'd0, coll2[i]}, 1 + 3 * i);

        // Reset mid-stream with five entries buffered
        reset_one(0);
        ready[0] = 1'b0;
        for (int i = 1; i <= 13; i++) push(0, W'(100 + i));
        chk("midrst.count_before", {28'd0, cnt[0]}, 5);
        in_en[0] = 1'b1; din[0] = W'(77);
        reset_one(0);
        chk("midrst.out_valid", {31'd0, oval[0]}, 0);
        chk("midrst.count", {28'd0, cnt[0]}, 0);
        for (int i = 1; i <= 4; i++) push(0, W'(200 + i));
        chk("midrst.warmup_count", {28'd0, cnt[0]}, 0);
        push(0, W'(205));
        chk("midrst.first_kept", {16'd0, dout[0]}, 205);

`ifdef FIR_SINK_PEAK_EN
        // Peak tracking
        reset_one(1);
        ready[1] = 1'b1;
        push(1, W'(3)); push(1, W'(9)); push(1, W'(2));
        chk("peak.max", {16'd0, pk[1]}, 9);
        pclr[1] = 1'b1;
        push(1, W'(4));
        chk("peak.clr_with_kept", {16'd0, pk[1]}, 4);
        pclr[1] = 1'b1;
        step();
        chk("peak.clr_alone", {16'd0, pk[1]}, 0);
`endif

        // Randomized traffic against the model
        for (int seg = 0; seg < 4; seg++) begin
            for (int c = 0; c < 120; c++) begin
                for (int k = 0; k < 3; k++) begin
                    in_en[k]   = ($urandom_range(0, 3) != 0);
                    din[k]     = W'($urandom);
                    ready[k]   = (seg[0]) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
                    clr_ovf[k] = ($urandom_range(0, 15) == 0);
                    pclr[k]    = ($urandom_range(0, 15) == 0);
                    rst[k]     = ($urandom_range(0, 79) == 0);
                end
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
